traffic_light_fsm: RTL and testbench
====================================

Name: traffic_light_fsm

Overview:
- Two-road intersection controller (NS and EW) with a pedestrian walk phase and a flash mode.
- Consumes the divided clock-enable level produced by the intersection clock divider; its rising edge is the 1-phase-unit tick.
- Runs entirely in the system clock domain. The divider output is never used as a clock.
- Drives lamp outputs and a seconds-remaining value for the display stage.

Parameters:
GREEN_T, 20, green duration in ticks (>=2)
YELLOW_T, 3, yellow duration in ticks (>=1)
ALLRED_T, 2, all-red clearance duration in ticks (>=1)
WALK_T, 6, all-red duration when a pedestrian request is serviced (>=1)
PED_MIN_T, 5, remaining green, in ticks, after a pedestrian request cuts green short (>=1, <GREEN_T)
TW, $clog2(max of all durations + 1), timer and remaining width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
clkdiv_in  in  1  divided-clock level from divider; rising edge = tick
ped_btn  in  1  pedestrian request, level, any length >=1 clk
flash_en  in  1  flash/night mode request, level
ns_light  out  3  {red,yellow,green} for NS
ew_light  out  3  {red,yellow,green} for EW
walk  out  1  pedestrian walk lamp
ped_pending  out  1  request latched, not yet serviced
remaining  out  TW  ticks left in current state, including the current one

Behaviour:
- Reset: all actions happen on a clk edge with rst==0.
  - State goes to ALLRED_B; timer loads ALLRED_T.
  - prev_div=1, so no spurious tick after reset.
  - ped latch=0, flash phase=0.
  - Outputs after the reset edge: ns_light=ew_light=3'b100, walk=0, ped_pending=0, remaining=ALLRED_T.
- Tick: tick = clkdiv_in & ~prev_div. prev_div is registered every clk. A tick is one clk wide per divider period.
- State sequence: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN. FLASH is separate.
- Timer:
  - On state entry the timer loads that state's duration D.
  - Each tick with timer>1 decrements it.
  - A tick with timer==1 moves to the next state at that same clk edge, loading the new D.
  - Each state therefore lasts exactly D ticks. remaining = timer.
- Lamps:
  - The green or yellow road shows its colour; the other road shows red.
  - ALLRED_A and ALLRED_B: both roads red.
- Pedestrian:
  - A ped_btn high at any clk (outside reset) sets the ped latch. Repeated presses while latched have no extra effect.
  - In a GREEN state with the latch set and timer>PED_MIN_T, timer is forced to PED_MIN_T on the next clk. This is one-shot, and a tick in that same cycle is ignored.
  - On entering ALLRED_A or ALLRED_B with the latch set:
    - the state's duration is WALK_T instead of ALLRED_T;
    - walk=1 for the whole state;
    - the latch clears on entry.
  - A press during a walk state re-latches for the next all-red.
- Flash:
  - flash_en==1 in any state moves to FLASH on the next clk, regardless of ticks.
  - In FLASH, flash phase toggles on each tick. ns_light=ew_light={0,phase,0}, walk=0, remaining=0. Ped presses still latch.
  - flash_en==0 while in FLASH moves to ALLRED_B on the next clk with timer=ALLRED_T. WALK_T applies if the latch is set.
- Simultaneous events: flash_en has highest priority. A timer transition beats a pedestrian shortening in the same clk.
- A reset during any state, including walk or FLASH, takes effect at that clk edge with the reset values above.

Test Plan:
Use GREEN_T=4, YELLOW_T=2, ALLRED_T=1, WALK_T=3, PED_MIN_T=2, with a divider period of 10 clk.
- Release reset, no inputs. Required: ALLRED_B for 1 tick, then NS green for 4 ticks (remaining 4,3,2,1), NS yellow for 2, ALLRED_A for 1, EW green for 4, EW yellow for 2, repeating. Never both roads non-red.
- Pulse ped_btn for 1 clk at NS_GREEN remaining=4. Required: next clk remaining=2 and ped_pending=1; after yellow, ALLRED_A lasts 3 ticks with walk=1; ped_pending=0 from entry.
- Press ped_btn at NS_GREEN remaining=2. Required: no shortening; walk occurs in the following ALLRED_A.
- Raise flash_en mid EW_GREEN. Required: next clk ns_light=ew_light=000, then 010/000 alternating per tick. Drop flash_en: next clk both red, remaining=1, then NS_GREEN.
- Hold clkdiv_in high through reset release. Required: no tick until the next rising edge of clkdiv_in.
- Drive rst=0 for 1 clk during a walk with remaining=2. Required: both lamps red, walk=0, ped_pending=0, remaining=1 on the next clk.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// Two-road intersection controller with a pedestrian walk phase and flash mode.
// The divider output is only sampled as a level; its rising edge is the
// phase-unit tick, detected here in the system clock domain.
module traffic_light_fsm #(
   parameter int GREEN_T   = 20,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int WALK_T    = 6,
   parameter int PED_MIN_T = 5,
   // derived widths; leave at their defaults
   parameter int MAX_GY    = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T,
   parameter int MAX_AW    = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T,
   parameter int MAX_T     = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW,
   parameter int TW        = $clog2(MAX_T + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clkdiv_in,
   input  logic          ped_btn,
   input  logic          flash_en,
   output logic [2:0]    ns_light,
   output logic [2:0]    ew_light,
   output logic          walk,
   output logic          ped_pending,
   output logic [TW-1:0] remaining
);

   typedef enum logic [2:0] {
      NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, FLASH
   } state_t;

   localparam logic [TW-1:0] D_GREEN  = TW'(GREEN_T);
   localparam logic [TW-1:0] D_YELLOW = TW'(YELLOW_T);
   localparam logic [TW-1:0] D_ALLRED = TW'(ALLRED_T);
   localparam logic [TW-1:0] D_WALK   = TW'(WALK_T);
   localparam logic [TW-1:0] D_PEDMIN = TW'(PED_MIN_T);
   localparam logic [TW-1:0] T_ONE    = TW'(1);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic          prev_div;
   logic          ped_latch, ped_latch_n;
   logic          walk_r, walk_n;
   logic          phase, phase_n;
   logic          tick;
   logic          enter_allred;

   assign tick = clkdiv_in & ~prev_div;

   // State and datapath registers; prev_div resets high so a divider level
   // held high through reset release is not mistaken for a rising edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ALLRED_B;
         timer     <= D_ALLRED;
         prev_div  <= 1'b1;
         ped_latch <= 1'b0;
         walk_r    <= 1'b0;
         phase     <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         prev_div  <= clkdiv_in;
         ped_latch <= ped_latch_n;
         walk_r    <= walk_n;
         phase     <= phase_n;
      end
   end

   // Next state: flash request, then flash exit, then timer expiry, then
   // pedestrian shortening of green, then plain countdown.
   always_comb begin
      state_n      = state;
      timer_n      = timer;
      ped_latch_n  = ped_latch | ped_btn;
      walk_n       = walk_r;
      phase_n      = phase;
      enter_allred = 1'b0;

      if (flash_en) begin
         state_n = FLASH;
         walk_n  = 1'b0;
         if (state != FLASH) phase_n = 1'b0;
         else if (tick)      phase_n = ~phase;
      end else if (state == FLASH) begin
         state_n      = ALLRED_B;
         enter_allred = 1'b1;
      end else if (tick && timer == T_ONE) begin
         walk_n = 1'b0;
         unique case (state)
            NS_GREEN:  begin state_n = NS_YELLOW; timer_n = D_YELLOW; end
            NS_YELLOW: begin state_n = ALLRED_A;  enter_allred = 1'b1; end
            ALLRED_A:  begin state_n = EW_GREEN;  timer_n = D_GREEN;  end
            EW_GREEN:  begin state_n = EW_YELLOW; timer_n = D_YELLOW; end
            EW_YELLOW: begin state_n = ALLRED_B;  enter_allred = 1'b1; end
            default:   begin state_n = NS_GREEN;  timer_n = D_GREEN;  end
         endcase
      end else if ((state == NS_GREEN || state == EW_GREEN) && ped_latch &&
                   timer > D_PEDMIN) begin
         // the tick in this cycle, if any, is deliberately dropped
         timer_n = D_PEDMIN;
      end else if (tick) begin
         timer_n = timer - T_ONE;
      end

      // All-red entry services a latched request; a press in the entry
      // cycle itself re-latches for the next all-red.
      if (enter_allred) begin
         if (ped_latch) begin
            timer_n     = D_WALK;
            walk_n      = 1'b1;
            ped_latch_n = ped_btn;
         end else begin
            timer_n = D_ALLRED;
            walk_n  = 1'b0;
         end
      end
   end

   // Lamp decode: the active road shows its colour, the other stays red.
   always_comb begin
      ns_light = RED;
      ew_light = RED;
      unique case (state)
         NS_GREEN:  ns_light = GRN;
         NS_YELLOW: ns_light = YEL;
         EW_GREEN:  ew_light = GRN;
         EW_YELLOW: ew_light = YEL;
         FLASH: begin
            ns_light = {1'b0, phase, 1'b0};
            ew_light = {1'b0, phase, 1'b0};
         end
         default: ;
      endcase
   end

   assign walk        = walk_r;
   assign ped_pending = ped_latch;
   assign remaining   = (state == FLASH) ? '0 : timer;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: directed scenarios followed by random
// ped/flash/reset traffic, all scored against a phase-table reference model.
module tb_traffic_light_fsm;

   localparam int G = 4, Y = 2, AR = 1, WK = 3, PM = 2;
   localparam int TW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clkdiv_in = 1'b1;
   logic          ped_btn = 1'b0;
   logic          flash_en = 1'b0;
   logic [2:0]    ns_light, ew_light;
   logic          walk, ped_pending;
   logic [TW-1:0] remaining;

   int checks = 0;
   int errors = 0;
   int divcnt = 5;

   // reference model: position in the six-phase cycle plus ticks left
   int m_idx, m_left, m_prev, m_ped, m_walk, m_phase, m_flash;

   traffic_light_fsm #(
      .GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(AR), .WALK_T(WK), .PED_MIN_T(PM)
   ) dut (
      .clk(clk), .rst(rst), .clkdiv_in(clkdiv_in), .ped_btn(ped_btn),
      .flash_en(flash_en), .ns_light(ns_light), .ew_light(ew_light),
      .walk(walk), .ped_pending(ped_pending), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // phase table: 0 NS green, 1 NS yellow, 2 all-red A, 3 EW green,
   // 4 EW yellow, 5 all-red B; duration 0 marks an all-red phase
   function automatic int dur(input int i);
      case (i)
         0, 3:    return G;
         1, 4:    return Y;
         default: return 0;
      endcase
   endfunction

   function automatic int ns_lamp(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int ew_lamp(input int i);
      case (i)
         3:       return 1;
         4:       return 2;
         default: return 4;
      endcase
   endfunction

   task automatic model(input int r, input int d, input int p, input int f);
      int tk, old_ped, enter;
      if (r == 0) begin
         m_idx = 5; m_left = AR; m_prev = 1; m_ped = 0;
         m_walk = 0; m_phase = 0; m_flash = 0;
         return;
      end
      tk = (d == 1 && m_prev == 0) ? 1 : 0;
      m_prev  = d;
      old_ped = m_ped;
      m_ped   = (m_ped != 0 || p != 0) ? 1 : 0;
      enter   = 0;
      if (f != 0) begin
         if (m_flash == 0) m_phase = 0;
         else if (tk != 0) m_phase = 1 - m_phase;
         m_flash = 1;
         m_walk  = 0;
      end else if (m_flash != 0) begin
         m_flash = 0; m_idx = 5; enter = 1;
      end else if (tk != 0 && m_left == 1) begin
         m_idx = (m_idx + 1) % 6;
         if (dur(m_idx) == 0) enter = 1;
         else begin m_left = dur(m_idx); m_walk = 0; end
      end else if ((m_idx == 0 || m_idx == 3) && old_ped != 0 && m_left > PM) begin
         m_left = PM;
      end else if (tk != 0) begin
         m_left = m_left - 1;
      end
      if (enter != 0) begin
         if (old_ped != 0) begin m_left = WK; m_walk = 1; m_ped = p; end
         else begin m_left = AR; m_walk = 0; end
      end
   endtask

   // one clk: drive inputs, advance model on the edge, compare just after it
   task automatic step(input int r, input int p, input int f);
      int d;
      d = (divcnt >= 5) ? 1 : 0;
      divcnt = (divcnt + 1) % 10;
      rst = r[0]; ped_btn = p[0]; flash_en = f[0]; clkdiv_in = d[0];
      @(posedge clk);
      #1;
      model(r, d, p, f);
      if (m_flash != 0) begin
         chk("ns", ns_light, {m_phase[0], 1'b0} << 0 == 0 ? 0 : {1'b0, m_phase[0], 1'b0});
         chk("ew", ew_light, {1'b0, m_phase[0], 1'b0});
         chk("rem", remaining, 0);
      end else begin
         chk("ns", ns_light, ns_lamp(m_idx));
         chk("ew", ew_light, ew_lamp(m_idx));
         chk("rem", remaining, m_left);
         chk("one_red", ns_light[2] | ew_light[2], 1);
      end
      chk("walk", walk, m_walk);
      chk("pend", ped_pending, m_ped);
      #3;
   endtask

   initial begin
      int n;
      int fl;
      #2;
      // reset with the divider held high, then release while still high
      step(0, 0, 0);
      step(0, 0, 0);
      chk("rst_ns", ns_light, 3'b100);
      chk("rst_ew", ew_light, 3'b100);
      chk("rst_walk", walk, 0);
      chk("rst_pend", ped_pending, 0);
      chk("rst_rem", remaining, AR);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0);
         chk("no_tick_rem", remaining, 1);
      end
      step(1, 0, 0);
      chk("first_tick_ns", ns_light, 3'b001);
      chk("first_tick_rem", remaining, 4);

      // pedestrian press at full green shortens it and earns a walk
      for (n = 0; n < 200 && !(m_flash == 0 && m_idx == 0 && m_left == 4 && m_ped == 0); n++)
         step(1, 0, 0);
      chk("reach_green4", n < 200, 1);
      step(1, 1, 0);
      step(1, 0, 0);
      chk("short_rem", remaining, 2);
      chk("short_pend", ped_pending, 1);
      for (n = 0; n < 100 && walk !== 1'b1; n++) step(1, 0, 0);
      chk("reach_walk", n < 100, 1);
      chk("walk_rem", remaining, WK);
      chk("walk_pend", ped_pending, 0);
      chk("walk_ns", ns_light, 3'b100);
      chk("walk_ew", ew_light, 3'b100);

      // reset in the middle of the walk
      for (n = 0; n < 40 && !(walk === 1'b1 && remaining == 2); n++) step(1, 0, 0);
      chk("reach_walk2", n < 40, 1);
      step(0, 0, 0);
      chk("wrst_ns", ns_light, 3'b100);
      chk("wrst_ew", ew_light, 3'b100);
      chk("wrst_walk", walk, 0);
      chk("wrst_pend", ped_pending, 0);
      chk("wrst_rem", remaining, 1);

      // press at remaining 2: no shortening, walk in the next all-red A
      for (n = 0; n < 200 && !(m_flash == 0 && m_idx == 0 && m_left == 2); n++)
         step(1, 0, 0);
      chk("reach_green2", n < 200, 1);
      step(1, 1, 0);
      step(1, 0, 0);
      chk("late_rem", remaining, 2);
      for (n = 0; n < 100 && ns_light != 3'b100; n++) step(1, 0, 0);
      chk("late_allred_walk", walk, 1);

      // flash during EW green, then release
      for (n = 0; n < 200 && !(m_flash == 0 && m_idx == 3 && m_ped == 0); n++)
         step(1, 0, 0);
      chk("reach_ewg", n < 200, 1);
      step(1, 0, 1);
      chk("fl_ns", ns_light, 3'b000);
      chk("fl_ew", ew_light, 3'b000);
      for (int i = 0; i < 30; i++) step(1, 0, 1);
      step(1, 0, 0);
      chk("flx_ns", ns_light, 3'b100);
      chk("flx_ew", ew_light, 3'b100);
      chk("flx_rem", remaining, 1);
      for (n = 0; n < 20 && ns_light != 3'b001; n++) step(1, 0, 0);
      chk("flx_nsg", n < 20, 1);

      // random traffic
      fl = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) fl = 1 - fl;
         step(($urandom_range(0, 999) == 0) ? 0 : 1,
              ($urandom_range(0, 29) == 0) ? 1 : 0, fl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
